// File: rtl/pe_operand_loader.sv
`default_nettype none
// ============================================================================
// pe_operand_loader: ping-pong deserializer, BF16 beat stream -> PE vector
// Revision: 1.0
// ============================================================================
module pe_operand_loader #(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_WORDS  = 576,
  parameter int BEAT_WORDS = 16
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             clear,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [DATA_WIDTH*BEAT_WORDS-1:0] in_data,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [DATA_WIDTH*NUM_WORDS-1:0]  out_vector
);

  localparam int c_beats     = NUM_WORDS / BEAT_WORDS;
  localparam int c_beat_bits = DATA_WIDTH * BEAT_WORDS;
  localparam int c_vec_bits  = DATA_WIDTH * NUM_WORDS;
  localparam int c_cnt_w     = (c_beats > 1) ? $clog2(c_beats) : 1;
  localparam logic [c_cnt_w-1:0] c_last_beat = c_cnt_w'(c_beats - 1);

  // Each bank is stored as one entry per beat; beat b holds words b*BEAT_WORDS..
  logic [c_beat_bits-1:0] r_bank [2][c_beats];
  logic                   r_wr_sel;
  logic                   r_rd_sel;
  logic [c_cnt_w-1:0]     r_beat_cnt;
  logic [1:0]             r_full_cnt;

  logic w_in_fire;
  logic w_out_fire;
  logic w_bank_done;

  assign in_ready    = (r_full_cnt != 2'd2);
  assign out_valid   = (r_full_cnt != 2'd0);
  assign w_in_fire   = in_valid && in_ready && !clear;
  assign w_out_fire  = out_valid && out_ready && !clear;
  assign w_bank_done = w_in_fire && (r_beat_cnt == c_last_beat);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_sel   <= 1'b0;
      r_rd_sel   <= 1'b0;
      r_beat_cnt <= '0;
      r_full_cnt <= 2'd0;
    end else if (clear) begin
      r_wr_sel   <= 1'b0;
      r_rd_sel   <= 1'b0;
      r_beat_cnt <= '0;
      r_full_cnt <= 2'd0;
    end else begin
      if (w_in_fire) begin
        r_beat_cnt <= w_bank_done ? '0 : r_beat_cnt + 1'b1;
      end
      if (w_bank_done) begin
        r_wr_sel <= ~r_wr_sel;
      end
      if (w_out_fire) begin
        r_rd_sel <= ~r_rd_sel;
      end
      // A completion and a consume in the same cycle leave the count unchanged
      case ({w_bank_done, w_out_fire})
        2'b10:   r_full_cnt <= r_full_cnt + 2'd1;
        2'b01:   r_full_cnt <= r_full_cnt - 2'd1;
        default: r_full_cnt <= r_full_cnt;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < 2; s++) begin
        for (int b = 0; b < c_beats; b++) begin
          r_bank[s][b] <= '0;
        end
      end
    end else if (w_in_fire) begin
      r_bank[r_wr_sel][r_beat_cnt] <= in_data;
    end
  end

  for (genvar b = 0; b < c_beats; b++) begin : g_out
    assign out_vector[c_vec_bits - b*c_beat_bits - 1 -: c_beat_bits] = r_bank[r_rd_sel][b];
  end

endmodule
`default_nettype wire

// File: tb/tb_pe_operand_loader.sv
`default_nettype none
// Bench for pe_operand_loader: directed scenarios plus random traffic, checked
// against a queue-of-vectors reference model.
module tb_pe_operand_loader;

  localparam int DW = 16;
  localparam int NW = 576;
  localparam int BW = 16;
  localparam int NB = NW / BW;
  localparam int VB = DW * NW;
  localparam int BB = DW * BW;

  logic          clk;
  logic          rst_n;
  logic          clear;
  logic          in_valid;
  logic          in_ready;
  logic [BB-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [VB-1:0] out_vector;

  pe_operand_loader #(
    .DATA_WIDTH(DW),
    .NUM_WORDS (NW),
    .BEAT_WORDS(BW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (clear),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_vector(out_vector)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int hs_cnt = 0;
  int hs_cyc [$];

  // Reference model: completed vectors waiting to be consumed, plus the words
  // of the vector currently being assembled.
  logic [VB-1:0] m_q [$];
  logic [DW-1:0] m_words [NW];
  int            m_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_vec(input string tag, input logic [VB-1:0] obs, input logic [VB-1:0] exp);
    int fk;
    fk = 0;
    checks++;
    assert (obs === exp) else begin
      errors++;
      for (int k = NW - 1; k >= 0; k--) begin
        if (obs[VB-DW*k-1 -: DW] !== exp[VB-DW*k-1 -: DW]) fk = k;
      end
      $error("FAIL %s word %0d observed %h expected %h", tag, fk,
             obs[VB-DW*fk-1 -: DW], exp[VB-DW*fk-1 -: DW]);
    end
  endtask

  function automatic logic [VB-1:0] pack_words();
    logic [VB-1:0] v;
    for (int k = 0; k < NW; k++) v[VB-DW*k-1 -: DW] = m_words[k];
    return v;
  endfunction

  function automatic logic [BB-1:0] beat_idx(input int b);
    logic [BB-1:0] d;
    for (int j = 0; j < BW; j++) d[BB-DW*j-1 -: DW] = DW'(16*b + j);
    return d;
  endfunction

  function automatic logic [BB-1:0] beat_const(input logic [DW-1:0] w);
    logic [BB-1:0] d;
    for (int j = 0; j < BW; j++) d[BB-DW*j-1 -: DW] = w;
    return d;
  endfunction

  function automatic logic [BB-1:0] beat_rand();
    logic [BB-1:0] d;
    for (int j = 0; j < BW; j++) d[BB-DW*j-1 -: DW] = DW'($urandom);
    return d;
  endfunction

  task automatic model_reset();
    m_q.delete();
    m_cnt = 0;
  endtask

  // One clock: check outputs against the model at the falling edge, drive the
  // inputs for the next rising edge, then advance the model.
  task automatic step(input logic v, input logic [BB-1:0] d, input logic ordy,
                      input logic clr, output logic acc);
    logic          exp_valid;
    logic          exp_ready;
    logic [VB-1:0] tmp;
    @(negedge clk);
    cyc++;
    exp_valid = (m_q.size() != 0);
    exp_ready = (m_q.size() < 2);
    chk("out_valid", {31'd0, out_valid}, {31'd0, exp_valid});
    chk("in_ready", {31'd0, in_ready}, {31'd0, exp_ready});
    if (exp_valid) chk_vec("out_vector", out_vector, m_q[0]);
    if (out_valid === 1'b1 && ordy && !clr) begin
      hs_cnt++;
      hs_cyc.push_back(cyc);
    end
    in_valid  = v;
    in_data   = d;
    out_ready = ordy;
    clear     = clr;
    acc = v && exp_ready && !clr;
    if (clr) begin
      model_reset();
    end else begin
      if (exp_valid && ordy) tmp = m_q.pop_front();
      if (acc) begin
        for (int j = 0; j < BW; j++) m_words[m_cnt*BW + j] = d[BB-DW*j-1 -: DW];
        m_cnt++;
        if (m_cnt == NB) begin
          m_q.push_back(pack_words());
          m_cnt = 0;
        end
      end
    end
  endtask

  initial begin
    logic          acc;
    logic [BB-1:0] d73;
    logic [VB-1:0] zero_vec;
    logic [VB-1:0] v5555;
    int            n_acc;

    zero_vec = '0;
    v5555    = {NW{16'h5555}};
    rst_n    = 1'b0;
    clear    = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    out_ready = 1'b0;

    #1;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk_vec("rst_out_vector", out_vector, zero_vec);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Single vector with word k = k
    for (int b = 0; b < NB; b++) step(1'b1, beat_idx(b), 1'b0, 1'b0, acc);
    step(1'b0, '0, 1'b0, 1'b0, acc);
    chk("single_valid", {31'd0, out_valid}, 32'd1);
    chk("single_w0", {16'd0, out_vector[9215:9200]}, 32'h0000);
    chk("single_w575", {16'd0, out_vector[15:0]}, 32'h023F);
    chk("single_w300", {16'd0, out_vector[DW*(NW-300)-1 -: DW]}, 32'h012C);

    // Backpressure: second vector fills the other bank, 73rd beat must wait
    for (int b = 0; b < NB; b++) step(1'b1, beat_rand(), 1'b0, 1'b0, acc);
    d73 = beat_rand();
    for (int i = 0; i < 3; i++) begin
      step(1'b1, d73, 1'b0, 1'b0, acc);
      chk("bp_held", {31'd0, acc}, 32'd0);
    end
    chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
    chk("bp_vec0_w575", {16'd0, out_vector[15:0]}, 32'h023F);
    step(1'b1, d73, 1'b1, 1'b0, acc);
    step(1'b1, d73, 1'b0, 1'b0, acc);
    chk("bp_73_accepted", {31'd0, acc}, 32'd1);
    step(1'b0, '0, 1'b0, 1'b1, acc);

    // Streaming: 10 vectors with both sides always ready
    hs_cnt = 0;
    hs_cyc.delete();
    n_acc = 0;
    for (int i = 0; i < 10 * NB; i++) begin
      step(1'b1, beat_rand(), 1'b1, 1'b0, acc);
      if (acc) n_acc++;
    end
    step(1'b0, '0, 1'b1, 1'b0, acc);
    chk("stream_accepts", n_acc, 10 * NB);
    chk("stream_handshakes", hs_cnt, 10);
    for (int i = 1; i < hs_cyc.size(); i++) chk("stream_spacing", hs_cyc[i] - hs_cyc[i-1], NB);
    step(1'b0, '0, 1'b0, 1'b1, acc);

    // Completion of the next vector coincides with consuming the current one
    for (int b = 0; b < NB; b++) step(1'b1, beat_rand(), 1'b0, 1'b0, acc);
    for (int b = 0; b < NB - 1; b++) step(1'b1, beat_rand(), 1'b0, 1'b0, acc);
    step(1'b1, beat_rand(), 1'b1, 1'b0, acc);
    step(1'b0, '0, 1'b0, 1'b0, acc);
    chk("simul_valid", {31'd0, out_valid}, 32'd1);
    chk("simul_in_ready", {31'd0, in_ready}, 32'd1);
    step(1'b0, '0, 1'b0, 1'b1, acc);

    // Clear mid-frame drops the partial 0xAAAA data and the coincident beat
    for (int b = 0; b < 20; b++) step(1'b1, beat_const(16'hAAAA), 1'b0, 1'b0, acc);
    step(1'b1, beat_const(16'hAAAA), 1'b0, 1'b1, acc);
    chk("clear_dropped", {31'd0, acc}, 32'd0);
    for (int b = 0; b < NB; b++) step(1'b1, beat_const(16'h5555), 1'b0, 1'b0, acc);
    step(1'b0, '0, 1'b0, 1'b0, acc);
    chk("clear_valid", {31'd0, out_valid}, 32'd1);
    chk_vec("clear_vec", out_vector, v5555);
    step(1'b0, '0, 1'b0, 1'b1, acc);

    // Asynchronous reset with one full bank and 10 pending beats
    for (int b = 0; b < NB + 10; b++) step(1'b1, beat_rand(), 1'b0, 1'b0, acc);
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("arst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("arst_in_ready", {31'd0, in_ready}, 32'd1);
    chk_vec("arst_out_vector", out_vector, zero_vec);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int b = 0; b < NB; b++) step(1'b1, beat_rand(), 1'b0, 1'b0, acc);
    step(1'b0, '0, 1'b0, 1'b0, acc);
    chk("arst_next_valid", {31'd0, out_valid}, 32'd1);

    // Random traffic
    step(1'b0, '0, 1'b0, 1'b1, acc);
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(99) < 70), beat_rand(), ($urandom_range(99) < 50),
           ($urandom_range(199) == 0), acc);
    end
    step(1'b0, '0, 1'b0, 1'b0, acc);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout observed no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire

// File: doc/pe_operand_loader.md
# pe_operand_loader

Deserializing ping-pong buffer that assembles a stream of narrow BF16 beats into the full 576-word operand vector consumed by the PE array. It is the fan-out counterpart of the 576-to-1 adder tree: that tree reduces PE outputs to one word, and this block expands a narrow input stream into the wide PE input. It sits between the feature/weight fetch path and the PE array, and uses double-buffering so the next vector loads while the current one is held.

## Interface
- DATA_WIDTH, 16, bits per BF16 word
- NUM_WORDS, 576, words per output vector
- BEAT_WORDS, 16, words per input beat; NUM_WORDS must be a multiple of BEAT_WORDS (BEATS = NUM_WORDS/BEAT_WORDS = 36)

- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- clear  in  1  synchronous flush of all buffered and partial data
- in_valid  in  1  input beat valid
- in_ready  out  1  loader can accept a beat
- in_data  in  DATA_WIDTH*BEAT_WORDS  beat; word j at [DATA_WIDTH*(BEAT_WORDS-j)-1 -: DATA_WIDTH]
- out_valid  out  1  complete vector available
- out_ready  in  1  PE array consumes vector
- out_vector  out  DATA_WIDTH*NUM_WORDS  word k at [DATA_WIDTH*(NUM_WORDS-k)-1 -: DATA_WIDTH], k = beat*BEAT_WORDS + j

## Operation
- Two banks, each NUM_WORDS words. State registers:
  - wr_sel: bank being filled.
  - rd_sel: bank being presented.
  - beat_cnt: 0..BEATS-1.
  - full_cnt: number of complete banks, 0..2.
- Input accept happens when in_valid && in_ready. The beat is written to bank[wr_sel] at word slots beat_cnt*BEAT_WORDS..+BEAT_WORDS-1, and beat_cnt increments.
- On accepting beat BEATS-1:
  - beat_cnt wraps to 0.
  - wr_sel toggles.
  - full_cnt increments.
- in_ready = (full_cnt != 2). It is purely a function of state and has no combinational path from out_ready.
- out_valid = (full_cnt != 0).
- out_vector = bank[rd_sel]. It must remain stable while out_valid && !out_ready.
- Output handshake happens when out_valid && out_ready. rd_sel toggles and full_cnt decrements.
- Simultaneous bank completion and output handshake in the same cycle: full_cnt is unchanged. Both wr_sel and rd_sel toggle.
- clear:
  - Zeroes beat_cnt, full_cnt, wr_sel and rd_sel. Bank contents are not cleared.
  - clear overrides any input or output handshake in the same cycle; that beat is dropped and no vector is consumed.
  - After clear, out_valid = 0 and in_ready = 1.
- Words are passed through bit-exact. There is no arithmetic and no reordering beyond the index mapping above.

## Timing
- Reset (asynchronous): all state registers and both banks go to 0. Consequently out_valid = 0, out_vector = 0, and in_ready = 1, both during and after reset.
- Reset asserted mid-frame discards partial and complete banks immediately.
- Latency: the last beat of a vector is accepted at edge N, and out_valid is 1 in the cycle following edge N, with the full vector on out_vector.
- Throughput: one beat per cycle, sustained. With out_ready held at 1, in_ready never deasserts, and one vector completes every BEATS cycles.
- Backpressure: with two complete banks and out_ready = 0, in_ready = 0. The first output handshake re-raises in_ready in the following cycle.
- in_data is sampled only on an accepted beat. Beats presented while in_ready = 0 must be held by the source (valid/ready rules).

## Test plan
- Single vector: after reset, send 36 beats with word value 16*b+j and out_ready = 0. Required response:
  - out_valid rises the cycle after the 36th accept.
  - out_vector word 0 (bits [9215:9200]) = 0x0000, word 575 (bits [15:0]) = 0x023F, word 300 = 0x012C.
- Backpressure: out_ready = 0, send 72 beats with in_valid held. Required response:
  - in_ready = 0 after the 72nd accept; the 73rd beat is held.
  - out_vector still shows vector 0.
  - Pulse out_ready for 1 cycle: out_vector shows vector 1 next cycle, in_ready = 1, and the 73rd beat is accepted.
- Streaming: in_valid = 1 and out_ready = 1 for 10 vectors (360 beats). Required response:
  - in_ready is never 0.
  - Exactly 10 output handshakes, spaced 36 cycles apart, each with correct contents.
- Simultaneous events: with full_cnt = 1 and out_ready = 1, the 36th beat of the next vector is accepted in the same cycle as the output handshake. Required response: out_valid stays 1 and out_vector switches to the new vector next cycle.
- Clear mid-frame: accept 20 beats of value 0xAAAA, then assert clear together with in_valid. Required response:
  - That beat is dropped.
  - A following 36-beat vector of value 0x5555 produces out_valid only after its 36th beat, with no 0xAAAA words in out_vector.
- Reset mid-operation: drop rst_n asynchronously with one complete bank and 10 beats pending. Required response:
  - out_valid = 0 and out_vector = 0 immediately.
  - After release, the next 36 beats form vector 0 correctly.
